// File: rtl/herm_rmv_ctrl_if.sv
// Stream, remover and status signals of the Hermitian-remover frame sequencer.
// master = sequencer side, slave = FFT source / remover / demapper / status side.
interface herm_rmv_ctrl_if;
    logic        en;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic        rmv_wren;
    logic [15:0] rmv_din;
    logic        rmv_tx_done;
    logic [8:0]  rmv_read_ptr;
    logic [15:0] rmv_dout;
    logic        rmv_full;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_last;
    logic        m_ready;
    logic        busy;
    logic        err;
    logic [15:0] frame_cnt;

    modport master (
        input  en, s_valid, s_data, rmv_dout, rmv_full, m_ready,
        output s_ready, rmv_wren, rmv_din, rmv_tx_done, rmv_read_ptr,
               m_valid, m_data, m_last, busy, err, frame_cnt
    );
    modport slave (
        output en, s_valid, s_data, rmv_dout, rmv_full, m_ready,
        input  s_ready, rmv_wren, rmv_din, rmv_tx_done, rmv_read_ptr,
               m_valid, m_data, m_last, busy, err, frame_cnt
    );
endinterface

// File: rtl/herm_rmv_ctrl.sv
// Frame sequencer: fills the Hermitian remover from the FFT stream, waits for its
// output buffer, drains it through a credit-limited read pipeline, then re-arms it.
module herm_rmv_ctrl #(
    parameter int FFT_POINT      = 64,
    parameter int SYM_TOTAL      = 12,
    parameter int ACTIVE_SUBCARR = 28,
    parameter int OUT_SYM        = 11,
    parameter int RD_LAT         = 3,
    parameter int WAIT_TIMEOUT   = 1024
) (
    input  logic             clk,
    input  logic             rst,
    herm_rmv_ctrl_if.master  bus
);
    localparam int IN_LEN  = FFT_POINT * SYM_TOTAL;
    localparam int OUT_LEN = ACTIVE_SUBCARR * OUT_SYM;
    localparam int IN_W    = $clog2(IN_LEN + 1);
    localparam int WT_W    = $clog2(WAIT_TIMEOUT + 1);

    localparam logic [IN_W-1:0] IN_LAST   = IN_W'(IN_LEN - 1);
    localparam logic [WT_W-1:0] WAIT_LAST = WT_W'(WAIT_TIMEOUT - 1);
    localparam logic [8:0]      OUT_END   = 9'(OUT_LEN);
    localparam logic [8:0]      OUT_LAST  = 9'(OUT_LEN - 1);

    typedef enum logic [2:0] {INIT, IDLE, FILL, WAIT_RMV, DRAIN, DONE} state_t;

    state_t               state_q, state_d;
    logic [IN_W-1:0]      in_cnt_q, in_cnt_d;
    logic [WT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic [8:0]           rd_ptr_q, rd_ptr_d;
    logic [8:0]           out_cnt_q, out_cnt_d;
    logic [8:0]           read_ptr_q, read_ptr_d;
    logic                 err_q, err_d;
    logic                 tmo_q, tmo_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic                 busy_q, busy_d;
    logic                 tx_done_q, tx_done_d;
    logic [RD_LAT-1:0]    vld_pipe_q, vld_pipe_d;
    logic [3:0][15:0]     fifo_q, fifo_d;
    logic [1:0]           hd_q, hd_d, tl_q, tl_d;
    logic [2:0]           cnt_q, cnt_d;

    logic       push, pop, issue, m_valid;
    logic [2:0] inflight;
    logic [3:0] used;

    assign m_valid = (cnt_q != 3'd0);
    assign pop     = m_valid & bus.m_ready;
    assign push    = vld_pipe_q[RD_LAT-1];

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) inflight = inflight + 3'(vld_pipe_q[i]);
    end

    // Credit counts a same-cycle pop so a steady drain issues every cycle.
    assign used = {1'b0, cnt_q} + {1'b0, inflight} - {3'b0, pop};

    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        rd_ptr_d    = rd_ptr_q;
        out_cnt_d   = out_cnt_q;
        read_ptr_d  = read_ptr_q;
        err_d       = err_q;
        tmo_d       = tmo_q;
        frame_cnt_d = frame_cnt_q;
        issue       = 1'b0;
        case (state_q)
            INIT: state_d = IDLE;
            IDLE: if (bus.en) state_d = FILL;
            FILL: begin
                if (bus.s_valid) begin
                    in_cnt_d = in_cnt_q + IN_W'(1);
                    if (in_cnt_q == IN_LAST) state_d = WAIT_RMV;
                end
            end
            WAIT_RMV: begin
                wait_cnt_d = wait_cnt_q + WT_W'(1);
                if (bus.rmv_full) begin
                    state_d = DRAIN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DRAIN: begin
                if (rd_ptr_q < OUT_END && used < 4'd4) begin
                    issue      = 1'b1;
                    read_ptr_d = rd_ptr_q;
                    rd_ptr_d   = rd_ptr_q + 9'd1;
                end
                if (pop) begin
                    out_cnt_d = out_cnt_q + 9'd1;
                    if (out_cnt_q == OUT_LAST) state_d = DONE;
                end
            end
            DONE: begin
                if (!tmo_q) frame_cnt_d = frame_cnt_q + 16'd1;
                tmo_d      = 1'b0;
                in_cnt_d   = '0;
                wait_cnt_d = '0;
                rd_ptr_d   = '0;
                out_cnt_d  = '0;
                read_ptr_d = '0;
                state_d    = IDLE;
            end
            default: state_d = INIT;
        endcase

        vld_pipe_d = {vld_pipe_q[RD_LAT-2:0], issue};
        fifo_d     = fifo_q;
        tl_d       = tl_q;
        hd_d       = hd_q;
        if (push) begin
            fifo_d[tl_q] = bus.rmv_dout;
            tl_d         = tl_q + 2'd1;
        end
        if (pop) hd_d = hd_q + 2'd1;
        cnt_d = cnt_q + {2'b0, push} - {2'b0, pop};

        // Registered so every output reads zero while rst is held.
        busy_d    = (state_d != IDLE);
        tx_done_d = (state_d == DONE) || (state_q == INIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT;
            in_cnt_q    <= '0;
            wait_cnt_q  <= '0;
            rd_ptr_q    <= '0;
            out_cnt_q   <= '0;
            read_ptr_q  <= '0;
            err_q       <= 1'b0;
            tmo_q       <= 1'b0;
            frame_cnt_q <= '0;
            busy_q      <= 1'b0;
            tx_done_q   <= 1'b0;
            vld_pipe_q  <= '0;
            fifo_q      <= '0;
            hd_q        <= '0;
            tl_q        <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            out_cnt_q   <= out_cnt_d;
            read_ptr_q  <= read_ptr_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
            frame_cnt_q <= frame_cnt_d;
            busy_q      <= busy_d;
            tx_done_q   <= tx_done_d;
            vld_pipe_q  <= vld_pipe_d;
            fifo_q      <= fifo_d;
            hd_q        <= hd_d;
            tl_q        <= tl_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.s_ready      = (state_q == FILL);
    assign bus.rmv_wren     = (state_q == FILL) & bus.s_valid;
    assign bus.rmv_din      = (state_q == FILL) ? bus.s_data : 16'h0;
    assign bus.rmv_tx_done  = tx_done_q;
    assign bus.rmv_read_ptr = read_ptr_q;
    assign bus.m_valid      = m_valid;
    assign bus.m_data       = fifo_q[hd_q];
    assign bus.m_last       = m_valid && (out_cnt_q == OUT_LAST);
    assign bus.busy         = busy_q;
    assign bus.err          = err_q;
    assign bus.frame_cnt    = frame_cnt_q;
endmodule
